// File: rtl/led_status_pkg.sv
// ============================================================================
// Module  : led_status_pkg
// Purpose : Shared mode/BEAT encodings, BEAT segment lengths and helpers for
//           the LED status controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package led_status_pkg;

    typedef enum logic [2:0] {
        MODE_OFF   = 3'd0,
        MODE_ON    = 3'd1,
        MODE_BLINK = 3'd2,
        MODE_BEAT  = 3'd3,
        MODE_ACT   = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        BEAT_ON1  = 2'd0,
        BEAT_OFF1 = 2'd1,
        BEAT_ON2  = 2'd2,
        BEAT_REST = 2'd3
    } beat_e;

    localparam logic [15:0] c_BEAT_ON1_MS  = 16'd100;
    localparam logic [15:0] c_BEAT_OFF1_MS = 16'd100;
    localparam logic [15:0] c_BEAT_ON2_MS  = 16'd100;
    localparam logic [15:0] c_BEAT_REST_MS = 16'd700;

    function automatic logic [15:0] beat_len(input beat_e s);
        logic [15:0] len;
        case (s)
            BEAT_ON1:  len = c_BEAT_ON1_MS;
            BEAT_OFF1: len = c_BEAT_OFF1_MS;
            BEAT_ON2:  len = c_BEAT_ON2_MS;
            default:   len = c_BEAT_REST_MS;
        endcase
        return len;
    endfunction

    function automatic beat_e beat_next(input beat_e s);
        beat_e n;
        case (s)
            BEAT_ON1:  n = BEAT_OFF1;
            BEAT_OFF1: n = BEAT_ON2;
            BEAT_ON2:  n = BEAT_REST;
            default:   n = BEAT_ON1;
        endcase
        return n;
    endfunction

    function automatic logic beat_led(input beat_e s);
        return (s == BEAT_ON1) || (s == BEAT_ON2);
    endfunction

    // A zero half-period would stall the blinker; treat it as one tick.
    function automatic logic [15:0] half_clamp(input logic [15:0] h);
        return (h == 16'd0) ? 16'd1 : h;
    endfunction

endpackage : led_status_pkg

`default_nettype wire

// File: rtl/led_tick_gen.sv
// ============================================================================
// Module  : led_tick_gen
// Purpose : 1 ms prescaler producing a registered single-cycle tick strobe.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module led_tick_gen #(
    parameter int CLK_FREQ_HZ = 125_000_000
) (
    input  logic i_clk,
    input  logic i_s_rst,
    output logic o_tick
);

    localparam int c_DIV   = CLK_FREQ_HZ / 1000;
    localparam int c_CNT_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_PRE  = c_CNT_W'(c_DIV - 2);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_tick;

    // The strobe is registered one count early so it coincides with terminal count.
    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= (r_cnt == c_LAST) ? '0 : r_cnt + c_CNT_W'(1);
            r_tick <= (r_cnt == c_PRE);
        end
    end

    assign o_tick = r_tick;

endmodule : led_tick_gen

`default_nettype wire

// File: rtl/led_status_ctrl.sv
// ============================================================================
// Module  : led_status_ctrl
// Purpose : Multi-channel LED status driver with OFF/ON/BLINK/BEAT/ACT modes.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module led_status_ctrl
    import led_status_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CLK_FREQ_HZ = 125_000_000,
    parameter int STRETCH_MS  = 50
) (
    input  logic                   i_clk,
    input  logic                   i_s_rst,
    input  logic [NUM_CH-1:0][1:0] i_mode,
    input  logic [NUM_CH-1:0]      i_act_en,
    input  logic [NUM_CH-1:0]      i_act,
    input  logic [NUM_CH-1:0][15:0] i_half_ms,
    output logic [NUM_CH-1:0]      o_led,
    output logic                   o_tick
);

    localparam logic [15:0] c_STRETCH = 16'(STRETCH_MS);

    logic w_tick;
    logic r_init;

    led_tick_gen #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ)
    ) u_tick_gen (
        .i_clk   (i_clk),
        .i_s_rst (i_s_rst),
        .o_tick  (w_tick)
    );

    assign o_tick = w_tick;

    // Forces every channel through a restart on the first cycle out of reset.
    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            r_init <= 1'b1;
        end else begin
            r_init <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        mode_e       w_eff;
        logic        w_restart;
        logic [15:0] w_half;
        mode_e       r_mode;
        beat_e       r_beat;
        logic [15:0] r_ms;
        logic [15:0] r_half;
        logic        r_led;

        always_comb begin
            w_eff     = i_act_en[g] ? MODE_ACT : mode_e'({1'b0, i_mode[g]});
            w_restart = r_init || (w_eff != r_mode);
            w_half    = half_clamp(i_half_ms[g]);
        end

        always_ff @(posedge i_clk) begin
            if (i_s_rst) begin
                r_mode <= MODE_OFF;
                r_beat <= BEAT_ON1;
                r_ms   <= 16'd0;
                r_half <= 16'd1;
                r_led  <= 1'b0;
            end else if (w_restart) begin
                r_mode <= w_eff;
                r_beat <= BEAT_ON1;
                r_ms   <= 16'd0;
                r_half <= w_half;
                case (w_eff)
                    MODE_ON, MODE_BLINK, MODE_BEAT: r_led <= 1'b1;
                    MODE_ACT: begin
                        r_led <= i_act[g];
                        r_ms  <= i_act[g] ? c_STRETCH : 16'd0;
                    end
                    default: r_led <= 1'b0;
                endcase
            end else begin
                case (r_mode)
                    MODE_ON: r_led <= 1'b1;
                    MODE_BLINK: begin
                        if (w_tick) begin
                            // New half-period length is sampled only at the boundary.
                            if (r_ms == r_half - 16'd1) begin
                                r_led  <= ~r_led;
                                r_ms   <= 16'd0;
                                r_half <= w_half;
                            end else begin
                                r_ms <= r_ms + 16'd1;
                            end
                        end
                    end
                    MODE_BEAT: begin
                        if (w_tick) begin
                            if (r_ms == beat_len(r_beat) - 16'd1) begin
                                r_beat <= beat_next(r_beat);
                                r_led  <= beat_led(beat_next(r_beat));
                                r_ms   <= 16'd0;
                            end else begin
                                r_ms <= r_ms + 16'd1;
                            end
                        end
                    end
                    MODE_ACT: begin
                        // A pulse on the expiring tick takes priority and re-arms.
                        if (i_act[g]) begin
                            r_led <= 1'b1;
                            r_ms  <= c_STRETCH;
                        end else if (w_tick && (r_ms != 16'd0)) begin
                            r_ms <= r_ms - 16'd1;
                            if (r_ms == 16'd1) begin
                                r_led <= 1'b0;
                            end
                        end
                    end
                    default: r_led <= 1'b0;
                endcase
            end
        end

        assign o_led[g] = r_led;
    end : g_ch

endmodule : led_status_ctrl

`default_nettype wire

// File: tb/tb_led_status_ctrl.sv
// ============================================================================
// Module  : tb_led_status_ctrl
// Purpose : Self-checking bench for led_status_ctrl (2 channels, 4-clock tick).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_led_status_ctrl;

    localparam int NCH     = 2;
    localparam int STRETCH = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NCH-1:0][1:0]  mode = '0;
    logic [NCH-1:0]       act_en = '0;
    logic [NCH-1:0]       act = '0;
    logic [NCH-1:0][15:0] half = '0;
    logic [NCH-1:0]       o_led;
    logic                 o_tick;

    int total = 0;
    int bad   = 0;

    // Reference model state (ticks since release, per-channel elapsed ticks)
    int   m_cyc = 0;
    logic m_tick = 1'b0;
    logic m_first = 1'b1;
    int   m_mode [NCH];
    int   m_n    [NCH];
    int   m_h    [NCH];
    int   m_rem  [NCH];
    logic m_led  [NCH];

    led_status_ctrl #(
        .NUM_CH      (NCH),
        .CLK_FREQ_HZ (4000),
        .STRETCH_MS  (STRETCH)
    ) dut (
        .i_clk     (clk),
        .i_s_rst   (rst),
        .i_mode    (mode),
        .i_act_en  (act_en),
        .i_act     (act),
        .i_half_ms (half),
        .o_led     (o_led),
        .o_tick    (o_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", name, m_cyc, got, exp);
        end
    endtask

    function automatic int clamp(input int h);
        return (h == 0) ? 1 : h;
    endfunction

    // Beat pattern: within a 1000-tick cycle, lit during [0,100) and [200,300).
    function automatic logic beat_on(input int n);
        return (n < 100) || (n >= 200 && n < 300);
    endfunction

    task automatic model_edge();
        int eff;
        for (int c = 0; c < NCH; c++) begin
            if (rst) begin
                m_mode[c] = 0;
                m_led[c]  = 1'b0;
                m_n[c]    = 0;
                m_rem[c]  = 0;
            end else begin
                eff = act_en[c] ? 4 : int'(mode[c]);
                if (m_first || eff != m_mode[c]) begin
                    m_mode[c] = eff;
                    m_n[c]    = 0;
                    m_h[c]    = clamp(int'(half[c]));
                    m_rem[c]  = (eff == 4 && act[c]) ? STRETCH : 0;
                    m_led[c]  = (eff >= 1 && eff <= 3) || (m_rem[c] > 0);
                end else begin
                    case (m_mode[c])
                        2: if (m_tick) begin
                            m_n[c]++;
                            if (m_n[c] == m_h[c]) begin
                                m_led[c] = ~m_led[c];
                                m_n[c]   = 0;
                                m_h[c]   = clamp(int'(half[c]));
                            end
                        end
                        3: if (m_tick) begin
                            m_n[c]   = (m_n[c] + 1) % 1000;
                            m_led[c] = beat_on(m_n[c]);
                        end
                        4: begin
                            if (act[c]) m_rem[c] = STRETCH;
                            else if (m_tick && m_rem[c] > 0) m_rem[c]--;
                            m_led[c] = (m_rem[c] > 0);
                        end
                        default: ;
                    endcase
                end
            end
        end
        m_first = rst;
        if (rst) begin
            m_cyc  = 0;
            m_tick = 1'b0;
        end else begin
            m_cyc++;
            m_tick = (m_cyc % 4 == 3);
        end
    endtask

    task automatic step();
        logic [NCH-1:0] exp_led;
        model_edge();
        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) exp_led[c] = m_led[c];
        chk("model_led", 32'(o_led), 32'(exp_led));
        chk("model_tick", 32'(o_tick), 32'(m_tick));
    endtask

    task automatic run_len(input int ch, input logic v, output int len);
        len = 0;
        while (o_led[ch] === v && len < 5000) begin
            len++;
            step();
        end
    endtask

    typedef struct {
        int          at;
        logic [15:0] half0;
        logic        exp_led0;
        logic        exp_tick;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int len;
        int k;
        int p;

        tbl[0]  = '{1, 16'd2, 1'b1, 1'b0};
        tbl[1]  = '{2, 16'd2, 1'b1, 1'b0};
        tbl[2]  = '{3, 16'd2, 1'b1, 1'b1};
        tbl[3]  = '{7, 16'd2, 1'b1, 1'b1};
        tbl[4]  = '{8, 16'd2, 1'b0, 1'b0};
        tbl[5]  = '{11, 16'd2, 1'b0, 1'b1};
        tbl[6]  = '{15, 16'd2, 1'b0, 1'b1};
        tbl[7]  = '{16, 16'd2, 1'b1, 1'b0};
        tbl[8]  = '{18, 16'd0, 1'b1, 1'b0};
        tbl[9]  = '{23, 16'd0, 1'b1, 1'b1};
        tbl[10] = '{24, 16'd0, 1'b0, 1'b0};
        tbl[11] = '{27, 16'd0, 1'b0, 1'b1};
        tbl[12] = '{28, 16'd0, 1'b1, 1'b0};
        tbl[13] = '{31, 16'd0, 1'b1, 1'b1};
        tbl[14] = '{32, 16'd0, 1'b0, 1'b0};
        tbl[15] = '{36, 16'd0, 1'b1, 1'b0};

        // Reset held 5 cycles; ch0 BLINK with half=2 waits behind it.
        mode[0] = 2'd2;
        half[0] = 16'd2;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("reset_led", 32'(o_led), 32'd0);
            chk("reset_tick", 32'(o_tick), 32'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            while (m_cyc < tbl[i].at) step();
            chk("tbl_led0", 32'(o_led[0]), 32'(tbl[i].exp_led0));
            chk("tbl_tick", 32'(o_tick), 32'(tbl[i].exp_tick));
            half[0] = tbl[i].half0;
        end

        // ch0 ON, ch1 BEAT; restart edge lands one cycle before a 3-clock wait to the first tick.
        mode[0] = 2'd1;
        mode[1] = 2'd3;
        step();
        run_len(1, 1'b1, len); chk("beat_on1_len", 32'(len), 32'd399);
        run_len(1, 1'b0, len); chk("beat_off1_len", 32'(len), 32'd400);
        run_len(1, 1'b1, len); chk("beat_on2_len", 32'(len), 32'd400);
        run_len(1, 1'b0, len); chk("beat_rest_len", 32'(len), 32'd2800);
        run_len(1, 1'b1, len); chk("beat_on1b_len", 32'(len), 32'd400);
        chk("on_ch0_steady", 32'(o_led[0]), 32'd1);

        // ACT on ch0: single pulse, then a pulse on the expiring tick.
        act_en[0] = 1'b1;
        step();
        chk("act_restart_off", 32'(o_led[0]), 32'd0);
        while (m_cyc % 4 != 0) step();
        p = m_cyc;
        act[0] = 1'b1; step(); act[0] = 1'b0;
        chk("act_pulse_on", 32'(o_led[0]), 32'd1);
        while (m_cyc < p + 11) step();
        chk("act_hold", 32'(o_led[0]), 32'd1);
        step();
        chk("act_clear", 32'(o_led[0]), 32'd0);
        while (m_cyc % 4 != 0) step();
        p = m_cyc;
        act[0] = 1'b1; step(); act[0] = 1'b0;
        chk("act2_on", 32'(o_led[0]), 32'd1);
        while (m_cyc < p + 11) step();
        act[0] = 1'b1; step(); act[0] = 1'b0;
        chk("act2_reload", 32'(o_led[0]), 32'd1);
        while (m_cyc < p + 23) step();
        chk("act2_hold", 32'(o_led[0]), 32'd1);
        step();
        chk("act2_clear", 32'(o_led[0]), 32'd0);

        // BLINK -> OFF mid on-phase.
        act_en[0] = 1'b0;
        mode[0]   = 2'd2;
        half[0]   = 16'd5;
        step();
        chk("blink_start", 32'(o_led[0]), 32'd1);
        for (int i = 0; i < 3; i++) step();
        mode[0] = 2'd0;
        step();
        chk("blink_to_off", 32'(o_led[0]), 32'd0);

        // Reset in the middle of a lit BEAT segment on ch1.
        k = 0;
        while (o_led[1] !== 1'b1 && k < 4000) begin
            step();
            k++;
        end
        chk("beat_wait_lit", 32'(o_led[1]), 32'd1);
        rst = 1'b1;
        step();
        chk("midrst_led1", 32'(o_led[1]), 32'd0);
        chk("midrst_tick", 32'(o_tick), 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("beat_after_rst", 32'(o_led[1]), 32'd1);
        run_len(1, 1'b1, len); chk("beat_rst_on1_len", 32'(len), 32'd399);
        chk("off_ch0_after_rst", 32'(o_led[0]), 32'd0);

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 49) == 0) mode[c] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 59) == 0) act_en[c] = ~act_en[c];
                if ($urandom_range(0, 9) == 0) half[c] = 16'($urandom_range(0, 3));
                act[c] = ($urandom_range(0, 5) == 0);
            end
            rst = ($urandom_range(0, 399) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_led_status_ctrl

`default_nettype wire
